// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity checker.
// Build option: define SERIAL_PARITY_ODD_EN for odd parity; otherwise even parity.
package serial_parity_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Parity error for a running XOR of the data bits and the received parity bit.
    function automatic logic parity_err(input logic acc, input logic pbit);
`ifdef SERIAL_PARITY_ODD_EN
        return ~(acc ^ pbit);
`else
        return acc ^ pbit;
`endif
    endfunction

endpackage

// File: rtl/parity_accumulator.sv
// One-bit running XOR of the data bits of the frame in flight.
// clear_load_i starts a new frame with bit_i; enable_i folds bit_i in.
module parity_accumulator (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_load_i,
    input  logic enable_i,
    input  logic bit_i,
    output logic acc_o
);

    logic acc_q;

    // Load on a new frame, accumulate on each further data bit, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else if (clear_load_i) begin
            acc_q <= bit_i;
        end else if (enable_i) begin
            acc_q <= acc_q ^ bit_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Receive side of a serial parity link: deserializes WIDTH data bits (LSB first)
// plus one parity bit and reports the word with a valid pulse and an error flag.
// Build option: SERIAL_PARITY_ODD_EN selects odd parity (default even).
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_bit,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity_err,
    output logic             out_abort,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               out_valid_q, out_abort_q, out_err_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               acc;

    logic start, data_bit, par_bit, restart;

    // A first-qualified bit always starts a frame; plain bits only count in DATA/PARITY.
    assign start    = in_valid & in_first;
    assign data_bit = in_valid & ~in_first & (state_q == ST_DATA);
    assign par_bit  = in_valid & ~in_first & (state_q == ST_PARITY);
    assign restart  = start & (state_q != ST_IDLE);
    assign cnt_inc  = cnt_q + CNT_ONE;

    parity_accumulator u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_load_i (start),
        .enable_i     (data_bit),
        .bit_i        (in_bit),
        .acc_o        (acc)
    );

    // Next state and bit counter; gaps (in_valid low) hold everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            cnt_d   = CNT_ONE;
            state_d = (WIDTH == 1) ? ST_PARITY : ST_DATA;
        end else if (data_bit) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
                state_d = ST_PARITY;
            end
        end else if (par_bit) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
    end

    // Shift register: bit 0 loads on a frame start, bit cnt loads on a data bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shreg
        assign shreg_d[gi] = start ? ((gi == 0) ? in_bit : 1'b0)
                           : (data_bit && (cnt_q == CW'(gi))) ? in_bit
                           : shreg_q[gi];
    end

    // Frame state plus output registers; outputs only change on a completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_valid_q <= 1'b0;
            out_abort_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_valid_q <= par_bit;
            out_abort_q <= restart;
            if (par_bit) begin
                out_data_q <= shreg_q;
                out_err_q  <= parity_err(acc, in_bit);
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_abort      = out_abort_q;
    assign out_data       = out_data_q;
    assign out_parity_err = out_err_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed testbench for serial_parity_checker (WIDTH = 8), both parity builds.
module tb_serial_parity_checker;

`ifdef SERIAL_PARITY_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_first = 1'b0;
    logic       in_bit = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_parity_err;
    logic       out_abort;
    logic       busy;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    serial_parity_checker #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_first       (in_first),
        .in_bit         (in_bit),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .out_abort      (out_abort),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        int         maxgap;
        logic       err_even;   // expected error in the even-parity build
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; return 1 ns after the rising edge.
    task automatic step(input logic v, input logic f, input logic b);
        @(negedge clk);
        in_valid = v;
        in_first = f;
        in_bit   = b;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int maxgap,
                              input logic exp_err);
        int n;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), d[i]);
            n = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (n) begin
                step(1'b0, 1'b0, 1'b0);
                check("busy_in_gap", busy, 1);
            end
        end
        step(1'b1, 1'b0, p);
        $display("[TB] frame data=%02h parity=%0b -> valid=%0b data=%02h err=%0b busy=%0b",
                 d, p, out_valid, out_data, out_parity_err, busy);
        check("valid_after_parity", out_valid, 1);
        check("data", out_data, d);
        check("err", out_parity_err, exp_err);
        check("no_abort", out_abort, 0);
        check("busy_after_frame", busy, 0);
        step(1'b0, 1'b0, 1'b0);
        check("valid_one_cycle", out_valid, 0);
        check("data_hold", out_data, d);
    endtask

    vec_t vecs [8];
    logic [7:0] d;
    int t0;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 0, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 5, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 3, 1'b0};
        vecs[5] = '{8'h7F, 1'b0, 0, 1'b1};
        vecs[6] = '{8'h01, 1'b1, 2, 1'b0};
        vecs[7] = '{8'h3C, 1'b0, 5, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", out_parity_err, 0);
        check("rst_abort", out_abort, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].maxgap, vecs[i].err_even ^ ODD);
        end

        // Restart: 4 bits, then a new first bit starting 0x01, parity 1
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        $display("[TB] restart -> abort=%0b valid=%0b busy=%0b", out_abort, out_valid, busy);
        check("restart_abort", out_abort, 1);
        check("restart_no_valid", out_valid, 0);
        check("restart_busy", busy, 1);
        check("restart_data_hold", out_data, 8'h3C);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 1) check("abort_one_cycle", out_abort, 0);
        end
        step(1'b1, 1'b0, 1'b1);
        $display("[TB] after restart -> valid=%0b data=%02h err=%0b", out_valid, out_data, out_parity_err);
        check("restart_valid", out_valid, 1);
        check("restart_data", out_data, 8'h01);
        check("restart_err", out_parity_err, 1'b0 ^ ODD);
        check("restart_valid_no_abort", out_abort, 0);

        // Back-to-back: 0x01/p1 then 0xFF/p0 with no idle cycles
        d = 8'h01;
        for (int i = 0; i < 8; i++) step(1'b1, (i == 0), d[i]);
        step(1'b1, 1'b0, 1'b1);
        t0 = cyc;
        $display("[TB] b2b frame1 -> valid=%0b data=%02h err=%0b", out_valid, out_data, out_parity_err);
        check("b2b1_valid", out_valid, 1);
        check("b2b1_data", out_data, 8'h01);
        check("b2b1_err", out_parity_err, 1'b0 ^ ODD);
        d = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), d[i]);
            if (i == 0) begin
                check("b2b_first_accepted", busy, 1);
                check("b2b_valid_drop", out_valid, 0);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        $display("[TB] b2b frame2 -> valid=%0b data=%02h err=%0b gap=%0d", out_valid, out_data, out_parity_err, cyc - t0);
        check("b2b2_valid", out_valid, 1);
        check("b2b2_data", out_data, 8'hFF);
        check("b2b2_err", out_parity_err, 1'b0 ^ ODD);
        check("b2b_spacing", cyc - t0, 9);
        // Non-first bit in IDLE is ignored
        step(1'b1, 1'b0, 1'b1);
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_valid", out_valid, 0);

        // Reset asserted mid-DATA
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset -> valid=%0b data=%02h err=%0b abort=%0b busy=%0b",
                 out_valid, out_data, out_parity_err, out_abort, busy);
        check("arst_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_abort", out_abort, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("post_rst_abort", out_abort, 0);
        check("post_rst_valid", out_valid, 0);
        send_frame(8'h80, 1'b1, 0, 1'b0 ^ ODD);
        send_frame(8'h80, 1'b0, 0, 1'b1 ^ ODD);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
